// File: rtl/accum_rr_scheduler_pkg.sv
// accum_pkg: shared types and helpers for the round-robin accumulator scheduler.
package accum_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, OUT} sched_state_t;
    typedef logic [1:0][6:0] bcd2_t;
    function automatic int src_id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/accum_rr_scheduler_rr_pick.sv
// rr_pick: combinational round-robin search for the first request at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);
    always_comb begin
        logic [IW-1:0] c;
        any = 1'b0;
        idx = '0;
        c   = '0;
        // walk from farthest to nearest so the nearest request wins
        for (int k = N - 1; k >= 0; k--) begin
            c = IW'((int'(ptr) + k) % N);
            if (req[c]) begin
                any = 1'b1;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/accum_rr_scheduler.sv
// accum_rr_scheduler: grants one stream source per frame, round-robin, to a shared BCD
// accumulator and returns its 2-digit result tagged with the source id.
module accum_rr_scheduler
    import accum_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int WIDTH     = 3,
    parameter int FRAME_LEN = 10,
    localparam int IW       = src_id_w(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_SRC-1:0]       s_valid,
    input  logic [NUM_SRC*WIDTH-1:0] s_data,
    output logic [NUM_SRC-1:0]       s_ready,
    output logic                     acc_s_valid,
    output logic [WIDTH-1:0]         acc_s_data,
    input  logic                     acc_s_ready,
    input  logic                     acc_m_valid,
    input  bcd2_t                    acc_m_data,
    output logic                     acc_m_ready,
    output logic                     m_valid,
    output bcd2_t                    m_data,
    output logic [IW-1:0]            m_id,
    input  logic                     m_ready
);
    localparam int CW = src_id_w(FRAME_LEN);

    sched_state_t  state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, m_id_q, m_id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    bcd2_t         m_data_q, m_data_d;
    logic          pick_any, streaming, beat, last_beat;
    logic [IW-1:0] pick_idx;
    logic [WIDTH-1:0] src_data [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_data[g] = s_data[g*WIDTH +: WIDTH];
    end

    rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
        .req (s_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign streaming   = state_q == STREAM;
    assign acc_s_valid = streaming && s_valid[grant_q];
    assign acc_s_data  = streaming ? src_data[grant_q] : '0;
    assign s_ready     = (streaming && acc_s_ready) ? {{(NUM_SRC-1){1'b0}}, 1'b1} << grant_q : '0;
    assign acc_m_ready = state_q == WAIT_RES;
    assign m_valid     = state_q == OUT;
    assign m_data      = m_data_q;
    assign m_id        = m_id_q;
    assign beat        = acc_s_valid && acc_s_ready;
    assign last_beat   = cnt_q == CW'(FRAME_LEN - 1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        m_data_d = m_data_q;
        m_id_d   = m_id_q;
        case (state_q)
            IDLE: if (pick_any) begin
                grant_d = pick_idx;
                state_d = STREAM;
            end
            STREAM: if (beat) begin
                cnt_d   = last_beat ? '0 : cnt_q + 1'b1;
                state_d = last_beat ? WAIT_RES : STREAM;
            end
            WAIT_RES: if (acc_m_valid) begin
                m_data_d = acc_m_data;
                m_id_d   = grant_q;
                state_d  = OUT;
            end
            OUT: if (m_ready) begin
                ptr_d   = (grant_q == IW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            m_data_q <= '0;
            m_id_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            m_data_q <= m_data_d;
            m_id_q   <= m_id_d;
        end
    end

    // a result before the frame is complete means the accumulator lost sync with us
    assert property (@(posedge clk) disable iff (!rstn) !(streaming && acc_m_valid))
        else $error("acc_m_valid asserted while streaming");
endmodule
